// File: rtl/intc_ctrl.sv
// intc_ctrl -- interrupt controller for the single-cycle core.
//
// Detects rising edges on NSRC synchronous interrupt lines and keeps
// per-source pending bits. It applies a software-writable enable mask and
// picks the lowest enabled pending index. It presents one request with its
// jump vector to the control unit and tracks the running handler until
// return-from-interrupt. Nesting is not supported.
//
// Ports:
//   clk         system clock, all state updates on rising edge
//   reset       synchronous, active-high reset
//   irq_in      interrupt lines, bit 0 highest priority
//   we_mask     mask write strobe from datapath
//   mask_data   new mask value (1 = source enabled)
//   int_ack     core accepts current request (PC pushed this cycle)
//   reti        core executes return-from-interrupt
//   int_req     interrupt request to control unit
//   int_vec     jump target for the requested source (0 when not requesting)
//   int_id      index of the requested / in-service source
//   in_service  handler currently running
//   pending     pending bits
//   mask        current mask register
module intc_ctrl #(
    parameter int unsigned      NSRC            = 4,
    parameter int unsigned      VEC_W           = 10,
    parameter logic [VEC_W-1:0] VEC_BASE        = 10'h3C0,
    parameter int unsigned      VEC_STRIDE_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  irq_in,
    input  logic             we_mask,
    input  logic [NSRC-1:0]  mask_data,
    input  logic             int_ack,
    input  logic             reti,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic [2:0]       int_id,
    output logic             in_service,
    output logic [NSRC-1:0]  pending,
    output logic [NSRC-1:0]  mask
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state_q;
    logic [NSRC-1:0]    irq_prev_q;
    logic [NSRC-1:0]    pending_q;
    logic [NSRC-1:0]    pending_d;
    logic [NSRC-1:0]    mask_q;
    logic [2:0]         int_id_q;
    logic               int_req_q;
    logic [VEC_W-1:0]   int_vec_q;
    logic               in_service_q;

    logic [NSRC-1:0]    irq_edge;
    logic [NSRC-1:0]    qual;
    logic [NSRC-1:0]    id_bit;
    logic               id_qual;
    logic [NSRC-1:0]    clr;
    logic [2:0]         sel;
    logic               sel_found;
    logic [VEC_W-1:0]   sel_vec;

    always_comb begin
        irq_edge  = irq_in & ~irq_prev_q;
        qual      = pending_q & mask_q;
        // One-hot of the locked source. A shift avoids an out-of-range
        // index when NSRC < 8.
        id_bit    = NSRC'(1) << int_id_q;
        id_qual   = |(qual & id_bit);

        // Lowest qualified index wins.
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (qual[i] && !sel_found) begin
                sel       = 3'(i);
                sel_found = 1'b1;
            end
        end
        sel_vec   = VEC_BASE + (VEC_W'(sel) << VEC_STRIDE_LOG2);

        // An edge arriving in the same cycle as the ack re-sets the bit,
        // so the set takes priority over the clear.
        clr       = (state_q == REQ && int_ack) ? id_bit : '0;
        pending_d = (pending_q & ~clr) | irq_edge;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            int_id_q     <= '0;
            int_req_q    <= 1'b0;
            int_vec_q    <= '0;
            in_service_q <= 1'b0;
        end else begin
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            if (we_mask) begin
                mask_q <= mask_data;
            end

            case (state_q)
                IDLE: begin
                    if (|qual) begin
                        int_id_q  <= sel;
                        int_vec_q <= sel_vec;
                        int_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // The ack is checked first, so an acknowledged request
                    // is serviced even if its source was masked this cycle.
                    if (int_ack) begin
                        in_service_q <= 1'b1;
                        int_req_q    <= 1'b0;
                        int_vec_q    <= '0;
                        state_q      <= SERVICE;
                    end else if (!id_qual) begin
                        int_req_q <= 1'b0;
                        int_vec_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                SERVICE: begin
                    if (reti) begin
                        in_service_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign int_req    = int_req_q;
    assign int_vec    = int_vec_q;
    assign int_id     = int_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: doc/intc_ctrl.md
Name: intc_ctrl

Overview:
Interrupt controller that schedules external event sources onto the single-cycle processor core.
- Detects rising edges on NSRC synchronous interrupt lines and keeps per-source pending bits.
- Applies a software-writable mask and resolves fixed priority.
- Presents one request plus a jump vector to the control unit, which takes it at an instruction boundary and pushes the PC on the return stack.
- Tracks in-service state until the core executes the return-from-interrupt. No nesting.

Parameters:
NSRC, 4, number of interrupt sources (2..8)
VEC_W, 10, program-counter / vector width in bits
VEC_BASE, 10'h3C0, vector address of source 0
VEC_STRIDE_LOG2, 2, log2 of vector spacing in instruction words

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
irq_in  input  NSRC  interrupt lines, synchronous to clk, bit 0 highest priority
we_mask  input  1  mask write strobe from datapath
mask_data  input  NSRC  new mask value (1 = source enabled)
int_ack  input  1  core accepts current request (PC pushed this cycle)
reti  input  1  core executes return-from-interrupt
int_req  output  1  interrupt request to control unit
int_vec  output  VEC_W  jump target for the requested source
int_id  output  3  index of the requested / in-service source
in_service  output  1  handler currently running
pending  output  NSRC  pending bits, readable through an input port
mask  output  NSRC  current mask register

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. On reset, all of the following are 0:
  - irq_prev, pending, mask, int_id, in_service
  - state (IDLE), int_req
  - int_vec, which is 0 while not requesting
- Edge detection:
  - irq_prev <= irq_in every cycle.
  - edge = irq_in & ~irq_prev.
  - A line already high when reset releases produces an edge on the first post-reset cycle.
- Pending bits:
  - pending[i] <= 1 when edge[i] is set.
  - Cleared only when int_ack is accepted for that source.
  - If an edge arrives on the same cycle its bit is cleared, set wins and the bit stays 1.
  - Masked sources still latch pending.
- Mask register: on we_mask, mask <= mask_data at the clock edge. The new mask takes effect on the next cycle.
- Qualification:
  - qual = pending & mask.
  - sel = lowest index i with qual[i] = 1.
- FSM (3 states):
  - IDLE:
    - If qual != 0: int_id <= sel, int_req <= 1, go to REQ.
    - int_req therefore rises one cycle after pending is visible.
  - REQ:
    - int_req = 1. int_vec = VEC_BASE + (int_id << VEC_STRIDE_LOG2), truncated to VEC_W bits.
    - int_id and int_vec are locked, so a higher-priority arrival does not change them.
    - If int_ack: clear pending[int_id], in_service <= 1, int_req <= 0, go to SERVICE.
    - Else if qual[int_id] = 0 (source masked meanwhile): int_req <= 0, go to IDLE.
    - int_ack wins over a same-cycle mask removal.
  - SERVICE:
    - int_req = 0; int_id is held.
    - On reti: in_service <= 0, go to IDLE. A new request can rise the cycle after IDLE is re-entered, giving a minimum one-cycle gap after reti.
    - New edges accumulate in pending.
- Ignored inputs:
  - int_ack outside REQ.
  - reti outside SERVICE.
  - int_ack and reti together are resolved by the current state only.
- int_vec is 0 outside REQ.
- Reset mid-operation (REQ or SERVICE): everything returns to reset values next cycle, pending contents are lost, and the mask becomes 0.
- int_id is 3 bits wide and zero-extended when NSRC < 8.

Test Plan:
1. Reset, then mask = 4'b1111, then pulse irq_in[2] for 1 cycle:
   - pending = 4'b0100 the cycle after the pulse; int_req = 1 one cycle later.
   - int_id = 2, int_vec = 10'h3C8.
2. Reset, then irq_in[1] and irq_in[3] rise together with mask = 4'b1111:
   - int_id = 1, int_vec = 10'h3C4.
   - After int_ack, pending = 4'b1000. After reti: one idle cycle, then int_req with int_id = 3 and int_vec = 10'h3CC.
3. Reset, then irq_in[0] held high during and after reset, mask still 0:
   - pending = 4'b0001 and int_req stays 0.
   - Write mask = 4'b0001: int_req = 1 two cycles after the we_mask edge.
4. In REQ for source 2 (no ack), write mask = 4'b0000:
   - int_req falls the cycle after the mask update and state returns to IDLE.
   - pending[2] remains 1.
5. In SERVICE for source 0, pulse irq_in[0] again and assert int_ack with no request:
   - in_service stays 1, pending = 4'b0001, int_req stays 0 until reti.
6. In SERVICE, assert reset for 1 cycle:
   - in_service = 0, pending = 0, mask = 0, int_req = 0, int_vec = 0.
   - A subsequent reti is ignored.
